apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester that drives transfers into the team's APB responders (GPIO, UART) from a simple local command/response port.
- Converts one accepted command into one APB SETUP+ACCESS transfer, waits for PREADY, then returns read data or completion.
- Sits between the system controller / test sequencer and the PSEL-decoded peripheral bus.

Parameters:
- PDATA_SIZE, 32, width of PADDR/PWDATA/PRDATA and the command data/address fields; multiple of 8
- NUM_SLV, 2, number of PSEL lines (one-hot); slave 0 = GPIO, slave 1 = UART
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit in PCLK cycles; used only when APB_TIMEOUT_EN is defined

Ports:
- PCLK  in  1  bus clock, all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready on a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_sel  in  $clog2(NUM_SLV)  target slave index
- cmd_addr  in  PDATA_SIZE  transfer address
- cmd_wdata  in  PDATA_SIZE  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  PDATA_SIZE  read data, valid with rsp_valid
- rsp_err  out  1  transfer aborted by timeout, valid with rsp_valid
- PSEL  out  NUM_SLV  one-hot slave select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  transfer direction
- PADDR  out  PDATA_SIZE  transfer address
- PWDATA  out  PDATA_SIZE  write data
- PRDATA  in  PDATA_SIZE  read data from the selected slave
- PREADY  in  1  slave completion

Behaviour:
- Reset (async, immediate): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
- Reset mid-transfer aborts the transfer with no response.
- All APB outputs and rsp_* outputs are registered.
- cmd_ready = (state==IDLE); it is combinational from state only.
- FSM states are IDLE, SETUP, ACCESS.
- IDLE: on cmd_valid, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, set PSEL[cmd_sel]=1, then go to SETUP. cmd_sel >= NUM_SLV gives PSEL=0; the transfer still runs and a timeout or hang follows.
- SETUP (exactly 1 cycle): PSEL held, PENABLE=0, then go to ACCESS with PENABLE=1.
- ACCESS: PSEL, PENABLE, PADDR, PWRITE and PWDATA are held stable.
- On a rising edge with PREADY=1: capture PRDATA into rsp_rdata on reads (rsp_rdata keeps its old value on writes), set rsp_valid=1 and rsp_err=0, clear PSEL and PENABLE, go to IDLE.
- PREADY=0 extends ACCESS indefinitely; the timeout path applies only with the macro.
- Latency: command accepted at edge N; SETUP during N..N+1; ACCESS from N+1. With zero wait states, rsp_valid is high for the cycle after edge N+2.
- Minimum 3 cycles per command; back-to-back commands are accepted at the IDLE cycle coinciding with rsp_valid.
- rsp_valid is a single-cycle pulse with no backpressure; consumer must sample it.
- PREADY and PRDATA are ignored outside ACCESS.
- PADDR/PWRITE/PWDATA keep their last values in IDLE (no toggling); only PSEL/PENABLE return to 0.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
- When the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0, the transfer aborts: PSEL/PENABLE go to 0, then IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- PREADY=1 on the same edge as the limit wins, giving a normal completion with rsp_err=0.
- Not defined: no counter; ACCESS waits forever; rsp_err is tied 0.

Test Plan:
- Write, slave 0, addr 0x1, data 0xFFFF0000, PREADY=1 in ACCESS -> PSEL=2'b01/PENABLE=0 one cycle, then PENABLE=1 with PADDR=1, PWRITE=1, PWDATA=0xFFFF0000; rsp_valid pulse with rsp_err=0 three cycles after accept.
- Read, slave 1, addr 0x0, slave returns PRDATA=0xA5A5_5A5A after 3 wait states -> ACCESS held 4 cycles, all APB outputs stable; rsp_rdata=0xA5A5_5A5A.
- cmd_valid held high for two commands -> second accepted on the rsp_valid cycle; no PSEL gap beyond the one IDLE cycle; cmd_ready=0 during SETUP/ACCESS.
- Assert PRESET during ACCESS of a read -> PSEL/PENABLE/rsp_valid go to 0 without a clock edge; after release, cmd_ready=1 and no response is emitted.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY stuck 0 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0.
- With APB_TIMEOUT_EN, PREADY rises exactly on the limit cycle -> normal completion, rsp_err=0.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: turns one local command into one APB SETUP+ACCESS transfer.
// Latency: accept at edge N, SETUP N..N+1, ACCESS from N+1, rsp_valid after edge N+2 (zero wait).
// Backpressure: cmd_ready only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
//
// Ports:
//   PCLK, PRESET                  clock, async active-high reset
//   cmd_valid/ready/write/sel/addr/wdata  local command port (valid/ready)
//   rsp_valid/rdata/err           completion pulse, read data, timeout abort flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY  APB requester side
// Optional: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles
// without PREADY (rsp_err=1); otherwise ACCESS waits forever and rsp_err is 0.
module apb_master #(
  parameter int PDATA_SIZE     = 32,
  parameter int NUM_SLV        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [((NUM_SLV > 1) ? $clog2(NUM_SLV) : 1)-1:0] cmd_sel,
  input  logic [PDATA_SIZE-1:0]         cmd_addr,
  input  logic [PDATA_SIZE-1:0]         cmd_wdata,
  output logic                          rsp_valid,
  output logic [PDATA_SIZE-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [NUM_SLV-1:0]            PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [PDATA_SIZE-1:0]         PADDR,
  output logic [PDATA_SIZE-1:0]         PWDATA,
  input  logic [PDATA_SIZE-1:0]         PRDATA,
  input  logic                          PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLV-1:0]      psel_q, psel_d, sel_onehot;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [PDATA_SIZE-1:0]   paddr_q, paddr_d;
  logic [PDATA_SIZE-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [PDATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  // An out-of-range select decodes to no PSEL line; the transfer still runs.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_onehot[i] = (int'(cmd_sel) == i);
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel_d   = sel_onehot;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        // PREADY wins over the timeout limit when both land on the same edge.
        if (PREADY) begin
          if (!pwrite_q) rsp_rdata_d = PRDATA;
          rsp_valid_d = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
`ifdef APB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, back-to-back, reset abort,
// and (with APB_TIMEOUT_EN) timeout abort and PREADY-on-limit completion.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [0:0]  cmd_sel;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY;

  int checks   = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.PDATA_SIZE(32), .NUM_SLV(2), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic sel, input logic [31:0] addr,
                       input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_sel   = sel;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; PRDATA = '0; PREADY = 1'b0;
    repeat (2) @(posedge PCLK);
    #3 PRESET = 1'b0;

    // Reset state
    chk("rst_psel", {30'd0, PSEL}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Write, slave 0, zero wait states (PREADY high even in SETUP: ignored)
    PREADY = 1'b1;
    issue(1'b1, 1'b0, 32'h1, 32'hFFFF_0000);
    tick();                                   // edge N: accept
    cmd_valid = 1'b0;
    chk("wr_setup_psel", {30'd0, PSEL}, 32'h1);
    chk("wr_setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("wr_setup_ready", {31'd0, cmd_ready}, 32'd0);
    chk("wr_paddr", PADDR, 32'h1);
    chk("wr_pwrite", {31'd0, PWRITE}, 32'd1);
    chk("wr_pwdata", PWDATA, 32'hFFFF_0000);
    tick();                                   // edge N+1: ACCESS
    chk("wr_acc_penable", {31'd0, PENABLE}, 32'd1);
    chk("wr_acc_psel", {30'd0, PSEL}, 32'h1);
    chk("wr_acc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();                                   // edge N+2: complete
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("wr_rsp_rdata_kept", rsp_rdata, 32'd0);
    chk("wr_done_psel", {30'd0, PSEL}, 32'd0);
    chk("wr_done_penable", {31'd0, PENABLE}, 32'd0);
    chk("wr_idle_paddr_held", PADDR, 32'h1);
    chk("wr_done_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("wr_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);

    // Read, slave 1, three wait states
    PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    issue(1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    tick();
    cmd_valid = 1'b0;
    chk("rd_setup_psel", {30'd0, PSEL}, 32'h2);
    chk("rd_pwrite", {31'd0, PWRITE}, 32'd0);
    tick();
    for (int w = 0; w < 3; w++) begin
      chk("rd_wait_penable", {31'd0, PENABLE}, 32'd1);
      chk("rd_wait_psel", {30'd0, PSEL}, 32'h2);
      chk("rd_wait_paddr", PADDR, 32'h0);
      chk("rd_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rd_wait_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    chk("rd_last_penable", {31'd0, PENABLE}, 32'd1);
    chk("rd_no_early_capture", rsp_rdata, 32'd0);
    PREADY = 1'b1;
    PRDATA = 32'hA5A5_5A5A;
    tick();
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_5A5A);
    chk("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rd_done_psel", {30'd0, PSEL}, 32'd0);
    tick();

    // Back-to-back writes with cmd_valid held high
    PRDATA = 32'h0BAD_0BAD;
    issue(1'b1, 1'b0, 32'h10, 32'h11);
    tick();                                   // A accepted
    issue(1'b1, 1'b1, 32'h20, 32'h22);
    chk("b2b_a_psel", {30'd0, PSEL}, 32'h1);
    chk("b2b_a_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("b2b_a_acc_ready", {31'd0, cmd_ready}, 32'd0);
    chk("b2b_a_paddr", PADDR, 32'h10);
    tick();
    chk("b2b_a_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_ready_on_rsp", {31'd0, cmd_ready}, 32'd1);
    tick();                                   // B accepted on rsp cycle
    cmd_valid = 1'b0;
    chk("b2b_b_psel", {30'd0, PSEL}, 32'h2);
    chk("b2b_b_paddr", PADDR, 32'h20);
    chk("b2b_b_pwdata", PWDATA, 32'h22);
    chk("b2b_b_rsp_low", {31'd0, rsp_valid}, 32'd0);
    tick();
    tick();
    chk("b2b_b_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rdata_kept", rsp_rdata, 32'hA5A5_5A5A);
    tick();

    // Reset during ACCESS of a read
    PREADY = 1'b0;
    issue(1'b0, 1'b0, 32'h4, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_mid_in_access", {31'd0, PENABLE}, 32'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_mid_psel", {30'd0, PSEL}, 32'd0);
    chk("rst_mid_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_rdata", rsp_rdata, 32'd0);
    PREADY = 1'b1;
    tick();
    #2 PRESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_post_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_post_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rst_post_psel", {30'd0, PSEL}, 32'd0);
    end

`ifdef APB_TIMEOUT_EN
    // PREADY stuck low: abort after 16 ACCESS cycles
    PREADY = 1'b0;
    PRDATA = 32'hCAFE_F00D;
    issue(1'b0, 1'b1, 32'h8, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();                                   // ACCESS cycle 1 begins
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("to_still_access", {31'd0, PENABLE}, 32'd1);
      chk("to_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
    end
    tick();
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_psel", {30'd0, PSEL}, 32'd0);
    chk("to_penable", {31'd0, PENABLE}, 32'd0);
    tick();

    // PREADY rises exactly on the limit edge: normal completion
    issue(1'b0, 1'b0, 32'hC, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int c = 0; c < 15; c++) tick();
    chk("lim_still_access", {31'd0, PENABLE}, 32'd1);
    PREADY = 1'b1;
    PRDATA = 32'h5555_AAAA;
    tick();
    chk("lim_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lim_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("lim_rsp_rdata", rsp_rdata, 32'h5555_AAAA);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
